// File: rtl/mcpu_mem_responder.sv
// ---------------------------------------------------------------------------
// mcpu_mem_responder
//
// Memory-side responder for the MCPU bus. A WORD_SIZE x 2^ADDR_WIDTH RAM is
// shared by two ports:
//   * an instruction fetch port with a fixed, registered one-cycle latency
//   * a data port with a wait-state FSM (IDLE -> WAIT -> RESP) that models a
//     slow data memory and ends every accepted request with a dready pulse
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - synchronous active-high reset (memory contents are kept)
//   re, we     - data read / write request, sampled only while idle
//   addr       - data address, latched when a request is accepted
//   datawr     - write data, latched when a request is accepted
//   datard     - read data, updated only when a read completes
//   dready     - one-cycle completion pulse for an accepted request
//   busy       - high whenever the data FSM is not idle
//   err        - one-cycle pulse when re and we are both high while idle
//   instraddr  - instruction fetch address, sampled every edge
//   instrrd    - word at instraddr as sampled on the previous edge
//
// WAIT_STATES must lie in 0..15 because the wait counter is 4 bits wide.
// ---------------------------------------------------------------------------
module mcpu_mem_responder #(
   parameter int WORD_SIZE   = 16,
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  re,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WORD_SIZE-1:0]  datawr,
   output logic [WORD_SIZE-1:0]  datard,
   output logic                  dready,
   output logic                  busy,
   output logic                  err,
   input  logic [ADDR_WIDTH-1:0] instraddr,
   output logic [WORD_SIZE-1:0]  instrrd
);

   localparam int         DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   logic [WORD_SIZE-1:0]  mem [DEPTH];

   state_t                state_q,    state_d;
   logic [3:0]            cnt_q,      cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
   logic [WORD_SIZE-1:0]  wdata_q,    wdata_d;
   logic                  is_write_q, is_write_d;
   logic [WORD_SIZE-1:0]  datard_q,   datard_d;
   logic                  dready_q,   dready_d;
   logic                  busy_q,     busy_d;
   logic                  err_q,      err_d;
   logic [WORD_SIZE-1:0]  instrrd_q,  instrrd_d;
   logic                  mem_we;

   // Next-state logic for the data FSM. A request is only looked at while
   // idle; exactly one of re/we is accepted, both together are rejected with
   // an err pulse. The access itself happens when the wait counter has run
   // down, and that same edge raises dready. busy is derived from the next
   // state so the registered flag covers the whole WAIT..RESP window.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      is_write_d = is_write_q;
      datard_d   = datard_q;
      dready_d   = 1'b0;
      err_d      = 1'b0;
      mem_we     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (re ^ we) begin
               addr_d     = addr;
               wdata_d    = datawr;
               is_write_d = we;
               cnt_d      = WAIT_INIT;
               state_d    = ST_WAIT;
            end else if (re && we) begin
               err_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (is_write_q) begin
                  mem_we = 1'b1;
               end else begin
                  datard_d = mem[addr_q];
               end
               dready_d = 1'b1;
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d    = (state_d != ST_IDLE);
      instrrd_d = mem[instraddr];
   end

   // State and output registers. Reset returns the FSM to idle and clears
   // every visible output, which also drops any request still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         is_write_q <= 1'b0;
         datard_q   <= '0;
         dready_q   <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         instrrd_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         is_write_q <= is_write_d;
         datard_q   <= datard_d;
         dready_q   <= dready_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         instrrd_q  <= instrrd_d;
      end
   end

   // RAM write port. It has no reset so contents survive reset; the write is
   // suppressed during reset so an aborted write never lands. A fetch of the
   // same word on the same edge still sees the old value.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[addr_q] <= wdata_q;
      end
   end

   assign datard  = datard_q;
   assign dready  = dready_q;
   assign busy    = busy_q;
   assign err     = err_q;
   assign instrrd = instrrd_q;

endmodule

// File: tb/tb_mcpu_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mcpu_mem_responder
//
// Directed bench for mcpu_mem_responder. Two instances share the clock and
// reset: dut with WAIT_STATES=2 and dut0 with WAIT_STATES=0. Inputs are
// driven 1 time unit after a rising edge and outputs are sampled at the same
// point, so each sample reflects the registers updated on that edge.
// ---------------------------------------------------------------------------
module tb_mcpu_mem_responder;

   logic        clk = 1'b0;
   logic        reset;

   logic        re, we;
   logic [7:0]  addr, instraddr;
   logic [15:0] datawr, datard, instrrd;
   logic        dready, busy, err;

   logic        re0, we0;
   logic [7:0]  addr0, instraddr0;
   logic [15:0] datawr0, datard0, instrrd0;
   logic        dready0, busy0, err0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   mcpu_mem_responder #(.WORD_SIZE(16), .ADDR_WIDTH(8), .WAIT_STATES(2)) dut (
      .clk(clk), .reset(reset), .re(re), .we(we), .addr(addr), .datawr(datawr),
      .datard(datard), .dready(dready), .busy(busy), .err(err),
      .instraddr(instraddr), .instrrd(instrrd)
   );

   mcpu_mem_responder #(.WORD_SIZE(16), .ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .re(re0), .we(we0), .addr(addr0), .datawr(datawr0),
      .datard(datard0), .dready(dready0), .busy(busy0), .err(err0),
      .instraddr(instraddr0), .instrrd(instrrd0)
   );

   // Free-running clock and an edge counter used to measure pulse spacing.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one data request on the selected instance (sel=1 -> dut0) and wait,
   // bounded, for its dready. lat is edges after the accept edge, -1 on timeout.
   task automatic access(input bit sel, input logic r, input logic w,
                         input logic [7:0] a, input logic [15:0] d,
                         output int lat, output int when);
      if (sel) begin re0 = r; we0 = w; addr0 = a; datawr0 = d; end
      else     begin re  = r; we  = w; addr  = a; datawr  = d; end
      tick();
      re = 1'b0; we = 1'b0; re0 = 1'b0; we0 = 1'b0;
      lat  = -1;
      when = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if ((sel ? dready0 : dready) === 1'b1) begin
            lat  = i;
            when = cyc;
            break;
         end
      end
   endtask

   // Write a word through the data port and let the FSM return to idle.
   task automatic poke(input bit sel, input logic [7:0] a, input logic [15:0] d);
      int lat, when;
      access(sel, 1'b0, 1'b1, a, d, lat, when);
      tick();
   endtask

   task automatic test_reset();
      checks++; if (datard !== 16'h0000) begin errors++; $display("[TB] FAIL reset_datard: got %h expected %h", datard, 16'h0000); end
      checks++; if (instrrd !== 16'h0000) begin errors++; $display("[TB] FAIL reset_instrrd: got %h expected %h", instrrd, 16'h0000); end
      checks++; if (dready !== 1'b0) begin errors++; $display("[TB] FAIL reset_dready: got %b expected 0", dready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
      checks++; if (busy0 !== 1'b0 || dready0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_dut0: got busy=%b dready=%b expected 0 0", busy0, dready0); end
   endtask

   // Write 0xBEEF to 0x10 with a cycle-by-cycle view of busy/dready, then
   // read it back.
   task automatic test_write_read();
      int lat, when;
      we = 1'b1; addr = 8'h10; datawr = 16'hBEEF;
      tick();
      we = 1'b0; addr = 8'hFF; datawr = 16'h0000;
      checks++; if (busy !== 1'b1 || dready !== 1'b0) begin errors++; $display("[TB] FAIL wr_e0: got busy=%b dready=%b expected 1 0", busy, dready); end
      for (int i = 1; i <= 2; i++) begin
         tick();
         checks++; if (busy !== 1'b1 || dready !== 1'b0) begin errors++; $display("[TB] FAIL wr_wait%0d: got busy=%b dready=%b expected 1 0", i, busy, dready); end
      end
      tick();
      checks++; if (busy !== 1'b1 || dready !== 1'b1) begin errors++; $display("[TB] FAIL wr_done: got busy=%b dready=%b expected 1 1", busy, dready); end
      checks++; if (datard !== 16'h0000) begin errors++; $display("[TB] FAIL wr_datard_kept: got %h expected %h", datard, 16'h0000); end
      tick();
      checks++; if (busy !== 1'b0 || dready !== 1'b0) begin errors++; $display("[TB] FAIL wr_idle: got busy=%b dready=%b expected 0 0", busy, dready); end
      access(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, lat, when);
      checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL rd_latency: got %0d expected %0d", lat, 3); end
      checks++; if (datard !== 16'hBEEF) begin errors++; $display("[TB] FAIL rd_data: got %h expected %h", datard, 16'hBEEF); end
      tick();
   endtask

   // Zero wait states: re held high through RESP must be ignored, and the
   // same re is taken at the next idle edge.
   task automatic test_wait0();
      poke(1'b1, 8'h05, 16'h1234);
      poke(1'b1, 8'h06, 16'h5678);
      re0 = 1'b1; addr0 = 8'h05;
      tick();
      checks++; if (busy0 !== 1'b1 || dready0 !== 1'b0) begin errors++; $display("[TB] FAIL w0_accept: got busy=%b dready=%b expected 1 0", busy0, dready0); end
      tick();
      checks++; if (dready0 !== 1'b1 || datard0 !== 16'h1234) begin errors++; $display("[TB] FAIL w0_read1: got dready=%b data=%h expected 1 1234", dready0, datard0); end
      addr0 = 8'h06;
      tick();
      checks++; if (busy0 !== 1'b0 || dready0 !== 1'b0) begin errors++; $display("[TB] FAIL w0_resp_ignore: got busy=%b dready=%b expected 0 0", busy0, dready0); end
      tick();
      checks++; if (busy0 !== 1'b1 || dready0 !== 1'b0) begin errors++; $display("[TB] FAIL w0_reaccept: got busy=%b dready=%b expected 1 0", busy0, dready0); end
      re0 = 1'b0;
      tick();
      checks++; if (dready0 !== 1'b1 || datard0 !== 16'h5678) begin errors++; $display("[TB] FAIL w0_read2: got dready=%b data=%h expected 1 5678", dready0, datard0); end
      tick();
   endtask

   // Both re and we in idle: one err pulse, no access, memory untouched.
   task automatic test_err();
      int lat, when;
      poke(1'b0, 8'h20, 16'h0000);
      re = 1'b1; we = 1'b1; addr = 8'h20; datawr = 16'hFFFF;
      tick();
      re = 1'b0; we = 1'b0;
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL err_pulse: got err=%b busy=%b expected 1 0", err, busy); end
      tick();
      checks++; if (err !== 1'b0 || busy !== 1'b0 || dready !== 1'b0) begin errors++; $display("[TB] FAIL err_clear: got err=%b busy=%b dready=%b expected 0 0 0", err, busy, dready); end
      tick(); tick(); tick();
      checks++; if (dready !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL err_no_resp: got dready=%b busy=%b expected 0 0", dready, busy); end
      access(1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, lat, when);
      checks++; if (lat !== 3 || datard !== 16'h0000) begin errors++; $display("[TB] FAIL err_mem_kept: got lat=%0d data=%h expected 3 0000", lat, datard); end
      tick();
   endtask

   // Fetch port latency, then a data write and fetch of the same word on the
   // same edge: old word first, new word on the following fetch.
   task automatic test_instr();
      logic [15:0] words [4];
      words[0] = 16'h9A05; words[1] = 16'h7101; words[2] = 16'h3012; words[3] = 16'hA200;
      for (int i = 0; i < 4; i++) poke(1'b0, 8'(i), words[i]);
      for (int i = 0; i < 4; i++) begin
         instraddr = 8'(i);
         tick();
         checks++; if (instrrd !== words[i]) begin errors++; $display("[TB] FAIL fetch_%0d: got %h expected %h", i, instrrd, words[i]); end
      end
      we = 1'b1; addr = 8'h02; datawr = 16'hC0DE; instraddr = 8'h02;
      tick();
      we = 1'b0;
      tick(); tick(); tick();
      checks++; if (dready !== 1'b1 || instrrd !== 16'h3012) begin errors++; $display("[TB] FAIL fetch_same_edge: got dready=%b instr=%h expected 1 3012", dready, instrrd); end
      tick();
      checks++; if (instrrd !== 16'hC0DE) begin errors++; $display("[TB] FAIL fetch_new_word: got %h expected %h", instrrd, 16'hC0DE); end
   endtask

   // Reset during the second wait cycle of a write aborts it completely.
   task automatic test_reset_mid();
      int lat, when;
      poke(1'b0, 8'h30, 16'h1111);
      instraddr = 8'h30;
      we = 1'b1; addr = 8'h30; datawr = 16'h5555;
      tick();
      we = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0 || dready !== 1'b0 || datard !== 16'h0000 || instrrd !== 16'h0000) begin
         errors++; $display("[TB] FAIL rstmid_outputs: got busy=%b dready=%b datard=%h instrrd=%h expected 0 0 0000 0000", busy, dready, datard, instrrd);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (dready !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_dready%0d: got dready=%b busy=%b expected 0 0", i, dready, busy); end
      end
      checks++; if (instrrd !== 16'h1111) begin errors++; $display("[TB] FAIL rstmid_fetch: got %h expected %h", instrrd, 16'h1111); end
      access(1'b0, 1'b1, 1'b0, 8'h30, 16'h0000, lat, when);
      checks++; if (lat !== 3 || datard !== 16'h1111) begin errors++; $display("[TB] FAIL rstmid_mem_kept: got lat=%0d data=%h expected 3 1111", lat, datard); end
      tick();
   endtask

   // Read, write, read issued at the earliest accept edges: dready pulses
   // five cycles apart (W+3 with W=2).
   task automatic test_back_to_back();
      int lat1, lat2, lat3, t1, t2, t3;
      logic [15:0] first;
      poke(1'b0, 8'h01, 16'hAAAA);
      access(1'b0, 1'b1, 1'b0, 8'h01, 16'h0000, lat1, t1);
      first = datard;
      tick();
      access(1'b0, 1'b0, 1'b1, 8'h02, 16'h5A5A, lat2, t2);
      tick();
      access(1'b0, 1'b1, 1'b0, 8'h02, 16'h0000, lat3, t3);
      checks++; if (lat1 !== 3 || lat2 !== 3 || lat3 !== 3) begin errors++; $display("[TB] FAIL b2b_latency: got %0d %0d %0d expected 3 3 3", lat1, lat2, lat3); end
      checks++; if (first !== 16'hAAAA) begin errors++; $display("[TB] FAIL b2b_read1: got %h expected %h", first, 16'hAAAA); end
      checks++; if ((t2 - t1) !== 5 || (t3 - t2) !== 5) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d %0d expected 5 5", t2 - t1, t3 - t2); end
      checks++; if (datard !== 16'h5A5A) begin errors++; $display("[TB] FAIL b2b_final: got %h expected %h", datard, 16'h5A5A); end
      tick();
   endtask

   // Safety net in case a wait somewhere never returns.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      re = 1'b0; we = 1'b0; addr = '0; datawr = '0; instraddr = '0;
      re0 = 1'b0; we0 = 1'b0; addr0 = '0; datawr0 = '0; instraddr0 = '0;
      tick();
      tick();
      test_reset();
      reset = 1'b0;
      tick();
      test_write_read();
      test_wait0();
      test_err();
      test_instr();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mcpu_mem_responder.md
Name: mcpu_mem_responder

Overview:
- Memory-side responder for the MCPU bus: a WORD_SIZE x 2^ADDR_WIDTH word RAM serving two ports.
- Instruction fetch port: registered, fixed one-cycle latency.
- Data port: re/we request, a configurable wait-state FSM, then a one-cycle dready completion pulse.
- Sits opposite the CPU's data and instruction request channels. It models a slow data memory, so the CPU-side handshake can be exercised with real latency.

Parameters:
WORD_SIZE, 16, data and instruction word width in bits
ADDR_WIDTH, 8, address width; memory depth is 2^ADDR_WIDTH words
WAIT_STATES, 2, extra cycles between request accept and data-port access (0..15)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
re  input  1  data read request, sampled only in IDLE
we  input  1  data write request, sampled only in IDLE
addr  input  ADDR_WIDTH  data address, latched at accept
datawr  input  WORD_SIZE  write data, latched at accept
datard  output  WORD_SIZE  read data; valid when dready=1, held until the next read completes
dready  output  1  one-cycle completion pulse for the accepted request
busy  output  1  high whenever the FSM is not in IDLE
err  output  1  one-cycle pulse: re and we both high in IDLE, request rejected
instraddr  input  ADDR_WIDTH  instruction fetch address, sampled every edge
instrrd  output  WORD_SIZE  mem[instraddr] as sampled at the previous edge

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, named reset.
- On reset:
  - State becomes IDLE and the wait counter is 0.
  - datard, instrrd, dready, busy and err all go to 0.
  - Memory contents are NOT cleared.
- Data FSM states: IDLE, WAIT, RESP.
- IDLE:
  - re^we at edge E0 -> latch addr, datawr and the request type; load counter=WAIT_STATES; go to WAIT.
  - re&we -> err=1 for one cycle; stay in IDLE; no memory access.
  - Neither asserted -> stay in IDLE.
- WAIT:
  - counter!=0 -> decrement.
  - counter==0 -> perform the access at this edge: a write updates mem[latched addr]; a read loads datard. Then go to RESP with dready=1.
  - re/we/addr/datawr are ignored while in WAIT.
- RESP: dready=0 at next edge; return to IDLE. Requests are not sampled in RESP.
- Latency and throughput:
  - dready is high in the cycle after edge E0+WAIT_STATES+1.
  - Earliest next accept is edge E0+WAIT_STATES+3.
- busy is registered: high from the cycle after E0 through the RESP cycle inclusive.
- datard changes only on read completion and keeps its value across writes.
- Instruction port:
  - instrrd <= mem[instraddr] on every edge, independent of the data FSM.
  - A data write and a fetch of the same address at the same edge: instrrd returns the OLD word; the new word is visible on the following fetch.
- Address wrap: none. Addresses are ADDR_WIDTH wide, so every address is valid; no bounds error.
- Reset mid-operation (WAIT or RESP):
  - The FSM aborts to IDLE.
  - A pending write is discarded (memory unchanged).
  - No dready pulse is issued.
- Widths: no arithmetic on data. The counter is 4 bits, and WAIT_STATES outside 0..15 is illegal.

Test Plan:
- WAIT_STATES=2: write 0xBEEF to addr 0x10 (we pulse at E0) -> busy high, dready pulse in cycle after E0+3. A subsequent read of 0x10 -> datard=0xBEEF with dready.
- WAIT_STATES=0: read addr 0x05 preloaded 0x1234 -> dready in cycle after E0+1, datard=0x1234. A new re held high during RESP is ignored; re=1 at E0+3 is accepted.
- re=1 and we=1 together in IDLE, addr 0x20 holding 0x0000, datawr=0xFFFF -> err pulse for 1 cycle, busy stays 0, no dready, mem[0x20] remains 0x0000.
- Instruction fetch: instraddr=0x00..0x03 preloaded 0x9A05,0x7101,0x3012,0xA200 -> instrrd shows each word one cycle later. During an active data write to 0x02, a same-edge fetch of 0x02 returns 0x3012 and the next fetch returns the new word.
- Reset mid-write: we to 0x30 with 0x5555, reset asserted in the second WAIT cycle -> no dready, busy=0 next cycle, mem[0x30] unchanged, datard=0, instrrd=0.
- Back-to-back: read 0x01, write 0x02, read 0x02, each issued at the earliest accept edge (E0, E0+W+3, ...) -> three dready pulses, spaced W+3 cycles apart; the final datard equals the written value.
